// File: rtl/error_frame_monitor.sv
// CAN error-frame monitor: votes samplePulse groups into bits, then tracks
// error flag, stuck-dominant condition and delimiter back to bus idle.
module error_frame_monitor #(
    parameter int SAMPLES    = 3,
    parameter int DOM_THRESH = 6,
    parameter int DELIM_LEN  = 8,
    parameter int STUCK_LEN  = 13,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dIn,
    input  logic             samplePulse,
    input  logic             multiSample,
    input  logic             clearCount,
    output logic             bitValid,
    output logic             bitValue,
    output logic             errorFrame,
    output logic             frameStart,
    output logic             frameEnd,
    output logic             delimError,
    output logic             stuckDominant,
    output logic [CNT_W-1:0] errorCount
);
    localparam int SMP_W = $clog2(SAMPLES + 1);
    localparam int DOM_W = $clog2(STUCK_LEN + 1);
    localparam int REC_W = $clog2(DELIM_LEN + 1);
    localparam logic [SMP_W-1:0] SAMPLES_V    = SMP_W'(SAMPLES);
    localparam logic [DOM_W-1:0] DOM_THRESH_V = DOM_W'(DOM_THRESH);
    localparam logic [DOM_W-1:0] STUCK_V      = DOM_W'(STUCK_LEN);
    localparam logic [REC_W-1:0] DELIM_V      = REC_W'(DELIM_LEN);

    typedef enum logic [1:0] {S_MON, S_FLAG, S_DELIM} state_t;

    logic [SMP_W-1:0] pulse_cnt_q, pulse_cnt_d, ones_cnt_q, ones_cnt_d;
    logic [SMP_W-1:0] group_len_q, group_len_d;
    logic [SMP_W-1:0] cur_len, next_pulses, next_ones;
    logic             bit_valid_q, bit_valid_d, bit_value_q, bit_value_d;

    state_t           state_q, state_d;
    logic [DOM_W-1:0] dom_cnt_q, dom_cnt_d, dom_inc;
    logic [REC_W-1:0] rec_cnt_q, rec_cnt_d, rec_inc;
    logic             error_frame_q, error_frame_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             delim_error_q, delim_error_d;
    logic             stuck_q, stuck_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Group length is fixed by the first pulse of a group; a pulse arriving
    // while bitValid is high simply starts the next group.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        group_len_d = group_len_q;
        bit_valid_d = 1'b0;
        bit_value_d = bit_value_q;
        cur_len     = (pulse_cnt_q == '0) ? (multiSample ? SAMPLES_V : SMP_W'(1)) : group_len_q;
        next_pulses = pulse_cnt_q + SMP_W'(1);
        next_ones   = ones_cnt_q + SMP_W'(dIn);
        if (samplePulse) begin
            group_len_d = cur_len;
            if (next_pulses == cur_len) begin
                bit_valid_d = 1'b1;
                bit_value_d = (next_ones > (cur_len >> 1));
                pulse_cnt_d = '0;
                ones_cnt_d  = '0;
            end else begin
                pulse_cnt_d = next_pulses;
                ones_cnt_d  = next_ones;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        dom_cnt_d     = dom_cnt_q;
        rec_cnt_d     = rec_cnt_q;
        stuck_d       = stuck_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        delim_error_d = 1'b0;
        dom_inc       = (dom_cnt_q == STUCK_V) ? dom_cnt_q : dom_cnt_q + DOM_W'(1);
        rec_inc       = (rec_cnt_q == DELIM_V) ? rec_cnt_q : rec_cnt_q + REC_W'(1);
        count_d       = clearCount ? '0 : count_q;
        if (bit_valid_q) begin
            case (state_q)
                S_MON: begin
                    if (!bit_value_q) begin
                        dom_cnt_d = dom_inc;
                        if (dom_inc == DOM_THRESH_V) begin
                            state_d       = S_FLAG;
                            frame_start_d = 1'b1;
                            if (count_d != '1) count_d = count_d + CNT_W'(1);
                        end
                    end else begin
                        dom_cnt_d = '0;
                    end
                end
                S_FLAG: begin
                    if (!bit_value_q) begin
                        dom_cnt_d = dom_inc;
                        if (dom_inc == STUCK_V) stuck_d = 1'b1;
                    end else begin
                        dom_cnt_d = '0;
                        stuck_d   = 1'b0;
                        if (DELIM_LEN == 1) begin
                            state_d     = S_MON;
                            frame_end_d = 1'b1;
                            rec_cnt_d   = '0;
                        end else begin
                            state_d   = S_DELIM;
                            rec_cnt_d = REC_W'(1);
                        end
                    end
                end
                S_DELIM: begin
                    if (bit_value_q) begin
                        rec_cnt_d = rec_inc;
                        if (rec_inc == DELIM_V) begin
                            state_d     = S_MON;
                            frame_end_d = 1'b1;
                            rec_cnt_d   = '0;
                        end
                    end else begin
                        // The aborting dominant bit is the first of a new run.
                        state_d       = S_MON;
                        dom_cnt_d     = DOM_W'(1);
                        rec_cnt_d     = '0;
                        delim_error_d = 1'b1;
                    end
                end
                default: state_d = S_MON;
            endcase
        end
        error_frame_d = (state_d != S_MON);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_cnt_q   <= '0;
            ones_cnt_q    <= '0;
            group_len_q   <= '0;
            bit_valid_q   <= 1'b0;
            bit_value_q   <= 1'b0;
            state_q       <= S_MON;
            dom_cnt_q     <= '0;
            rec_cnt_q     <= '0;
            error_frame_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            delim_error_q <= 1'b0;
            stuck_q       <= 1'b0;
            count_q       <= '0;
        end else begin
            pulse_cnt_q   <= pulse_cnt_d;
            ones_cnt_q    <= ones_cnt_d;
            group_len_q   <= group_len_d;
            bit_valid_q   <= bit_valid_d;
            bit_value_q   <= bit_value_d;
            state_q       <= state_d;
            dom_cnt_q     <= dom_cnt_d;
            rec_cnt_q     <= rec_cnt_d;
            error_frame_q <= error_frame_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            delim_error_q <= delim_error_d;
            stuck_q       <= stuck_d;
            count_q       <= count_d;
        end
    end

    assign bitValid      = bit_valid_q;
    assign bitValue      = bit_value_q;
    assign errorFrame    = error_frame_q;
    assign frameStart    = frame_start_q;
    assign frameEnd      = frame_end_q;
    assign delimError    = delim_error_q;
    assign stuckDominant = stuck_q;
    assign errorCount    = count_q;
endmodule
